modulo_leitor_buffer_rolhas: RTL
================================

Name: modulo_leitor_buffer_rolhas

Overview:
Consumer (reader) end of the main cork buffer: the sealing station requests one cork per bottle from the main buffer and waits for the buffer side to acknowledge the decrement. The block also drives the sealing actuator for a fixed time, raises a no-cork flag, and keeps a consumed-cork count. It sits between the filling/sealing state machine (seal request, derived from ve) and the main-buffer down-counter (rd_req drives the counter enable, rd_ack returns its confirmation).

Parameters:
SEAL_CYCLES, 4, clk cycles the actuator output stays high per bottle (≥1)
ACK_TIMEOUT, 8, max clk cycles in REQ waiting for rd_ack before FAULT (≥1)
BUF_W, 5, width of the main buffer level input

Ports:
clk  in  1  system clock (divided clock domain)
clr  in  1  synchronous active-low reset
seal_req  in  1  level from the sealing state machine; rising edge = new bottle to seal
buf_count  in  BUF_W  current main cork buffer level
rd_ack  in  1  one-cycle pulse from the buffer side: decrement done
fault_clr  in  1  clears FAULT (active-high, sampled on clk)
rd_req  out  1  cork request to the buffer; held until rd_ack or timeout
seal_act  out  1  sealing actuator enable
seal_done  out  1  one-cycle pulse after each completed seal
ro  out  1  no cork available (state EMPTY)
fault  out  1  handshake timeout latched (state FAULT)
consumed  out  7  corks consumed, 0..99, wraps 99→0
state  out  3  current state encoding, for debug/LEDs

Behaviour:
- Reset: clr=0 sampled at a clk edge → state IDLE. All outputs 0, consumed=0, edge register=0, timers=0. Reset has priority over every other input, including mid-handshake or mid-seal.
- Edge detect: seal_req is registered every cycle. rise = seal_req & ~seal_req_q.
- State encoding: IDLE=0, REQ=1, SEAL=2, DONE=3, EMPTY=4, FAULT=5.
- IDLE:
  - On rise with buf_count==0 → EMPTY.
  - On rise with buf_count≠0 → REQ.
  - A rise in any other state is ignored, not queued.
- REQ:
  - rd_req=1. The timer counts cycles spent in REQ.
  - rd_ack=1 → SEAL. consumed increments on the same edge.
  - Timer reaches ACK_TIMEOUT without rd_ack → FAULT.
  - rd_ack and the timeout on the same cycle: ack wins.
- SEAL:
  - seal_act=1 for exactly SEAL_CYCLES cycles, then → DONE.
- DONE:
  - seal_done=1 for one cycle, then → IDLE.
- EMPTY:
  - ro=1, rd_req=0.
  - buf_count≠0 while seal_req=1 → REQ (auto-retry of the same bottle).
  - seal_req=0 → IDLE (bottle withdrawn).
- FAULT:
  - fault=1, all other outputs 0.
  - Exit only via fault_clr=1 (→ IDLE) or reset.
  - seal_req and buf_count are ignored.
- rd_ack outside REQ: ignored, no count change.
- Output registering: all outputs are registered and derived from the current state. Latency is 1 clk from a state change to its output.
- Seal latency: rise to rd_req = 1 clk; rd_ack to seal_act = 1 clk.
- consumed counter:
  - 7-bit unsigned.
  - Increments only on rd_ack accepted in REQ.
  - Value 99 plus an increment gives 0.
  - Values >99 are unreachable.

Optional Feature:
Macro LEITOR_ROLHAS_BCD_EN.
- Defined: adds outputs cons_dez[3:0] and cons_uni[3:0], the registered BCD tens and units of consumed. They update on the same edge as consumed and reset to 0. They feed the display mux directly.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset mid-operation: clr=0 while in SEAL → next edge state=IDLE, seal_act=0, consumed=0.
- Normal seal (SEAL_CYCLES=4, buf_count=5): seal_req rises; rd_ack 2 cycles after rd_req → rd_req high 2 cycles, consumed 0→1, seal_act high exactly 4 cycles, then seal_done single pulse, state IDLE.
- Empty then refill: buf_count=0, seal_req rises → ro=1, rd_req=0. buf_count set to 3 with seal_req still high → ro=0, rd_req=1 next cycle; completes with consumed+1.
- Timeout (ACK_TIMEOUT=8): rd_ack never asserted → fault=1 after 8 cycles in REQ, rd_req=0, consumed unchanged. fault_clr pulse → IDLE, fault=0.
- Ack/timeout collision: rd_ack asserted on the 8th REQ cycle → SEAL, no fault, consumed+1.
- Wrap and BCD: 100 seals from reset → consumed sequence ends 98, 99, 0. With LEITOR_ROLHAS_BCD_EN, at consumed=99 expect cons_dez=9, cons_uni=9, then both 0.

Source files
------------

// File: rtl/modulo_leitor_buffer_rolhas.sv
// Reader end of the main cork buffer: requests one cork per bottle, waits for
// the buffer's decrement acknowledge, runs the sealing actuator for a fixed
// time and keeps a wrapping 0..99 count of consumed corks.
// Optional feature: define LEITOR_ROLHAS_BCD_EN to add registered BCD tens/units
// outputs (cons_dez, cons_uni) of the consumed count.
module modulo_leitor_buffer_rolhas #(
    parameter int unsigned SEAL_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned BUF_W       = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             seal_req,
    input  logic [BUF_W-1:0] buf_count,
    input  logic             rd_ack,
    input  logic             fault_clr,
    output logic             rd_req,
    output logic             seal_act,
    output logic             seal_done,
    output logic             ro,
    output logic             fault,
    output logic [6:0]       consumed,
    output logic [2:0]       state
`ifdef LEITOR_ROLHAS_BCD_EN
    ,
    output logic [3:0]       cons_dez,
    output logic [3:0]       cons_uni
`endif
);

    // One timer is shared by REQ (ack timeout) and SEAL (actuator on-time).
    localparam int unsigned TMax = (ACK_TIMEOUT > SEAL_CYCLES) ? ACK_TIMEOUT : SEAL_CYCLES;
    localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StSeal  = 3'd2,
        StDone  = 3'd3,
        StEmpty = 3'd4,
        StFault = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    consumed_q, consumed_d;
    logic          seal_req_q;
    logic          rise;
    logic          buf_empty;

    assign rise      = seal_req & ~seal_req_q;
    assign buf_empty = (buf_count == '0);
    assign consumed  = consumed_q;
    assign state     = state_q;

    // Next state, shared timer and consumed count.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        consumed_d = consumed_q;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (rise) begin
                    state_d = buf_empty ? StEmpty : StReq;
                end
            end
            StReq: begin
                // Ack wins over a timeout on the same cycle.
                if (rd_ack) begin
                    state_d    = StSeal;
                    timer_d    = '0;
                    consumed_d = (consumed_q == 7'd99) ? 7'd0 : consumed_q + 7'd1;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d = StFault;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StSeal: begin
                if (timer_q == TW'(SEAL_CYCLES - 1)) begin
                    state_d = StDone;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                timer_d = '0;
            end
            StEmpty: begin
                timer_d = '0;
                // Bottle withdrawn takes precedence over a refill.
                if (!seal_req) begin
                    state_d = StIdle;
                end else if (!buf_empty) begin
                    state_d = StReq;
                end
            end
            StFault: begin
                timer_d = '0;
                if (fault_clr) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

`ifdef LEITOR_ROLHAS_BCD_EN
    logic [3:0] dez_q, dez_d, uni_q, uni_d;

    assign cons_dez = dez_q;
    assign cons_uni = uni_q;

    // BCD digits follow every increment of the binary count.
    always_comb begin
        dez_d = dez_q;
        uni_d = uni_q;
        if (consumed_d != consumed_q) begin
            if (consumed_q == 7'd99) begin
                dez_d = 4'd0;
                uni_d = 4'd0;
            end else if (uni_q == 4'd9) begin
                dez_d = dez_q + 4'd1;
                uni_d = 4'd0;
            end else begin
                uni_d = uni_q + 4'd1;
            end
        end
    end

    // BCD digit registers.
    always_ff @(posedge clk) begin
        if (!clr) begin
            dez_q <= 4'd0;
            uni_q <= 4'd0;
        end else begin
            dez_q <= dez_d;
            uni_q <= uni_d;
        end
    end
`endif

    // State, timer, count and outputs; outputs decode the incoming state so
    // they line up with the state register.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            consumed_q <= 7'd0;
            seal_req_q <= 1'b0;
            rd_req     <= 1'b0;
            seal_act   <= 1'b0;
            seal_done  <= 1'b0;
            ro         <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            consumed_q <= consumed_d;
            seal_req_q <= seal_req;
            rd_req     <= (state_d == StReq);
            seal_act   <= (state_d == StSeal);
            seal_done  <= (state_d == StDone);
            ro         <= (state_d == StEmpty);
            fault      <= (state_d == StFault);
        end
    end

endmodule
